shift_engine: RTL and testbench

SHIFT_ENGINE -- requirements
Module: shift_engine

---
 rtl/shift_engine.sv | 111 +++++++++++
 tb/tb_shift_engine.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/shift_engine.sv
// rtl/shift_engine.sv - multi-cycle SLL/SRL/SRA/ROR engine shifting up to STEP bits per cycle
module shift_engine #(
  parameter int DATA_W    = 32,
  parameter int STEP      = 1,
  parameter int AMT_CONST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [1:0]        amt_sel,
  input  logic [15:0]       in_shamt,
  input  logic [DATA_W-1:0] in_regb,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int AMT_W = $clog2(DATA_W);
  // One extra bit so a STEP equal to DATA_W is representable.
  localparam int K_W = AMT_W + 1;
  localparam logic [AMT_W-1:0] AMT_CONST_T = AMT_W'(AMT_CONST);
  localparam logic [K_W-1:0]   STEP_K      = K_W'(STEP);
  localparam logic [K_W-1:0]   WIDTH_K     = K_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  logic [1:0]        op_q, op_d;

  logic [AMT_W-1:0]  eff_amt;
  logic [K_W-1:0]    rem_ext;
  logic [K_W-1:0]    k;
  logic [DATA_W-1:0] shifted;
  logic              unused_bits;

  assign unused_bits = ^{in_shamt[15:AMT_W], in_regb[DATA_W-1:AMT_W], in_mem[DATA_W-1:AMT_W]};

  always_comb begin
    eff_amt = '0;
    case (amt_sel)
      2'b00:   eff_amt = in_shamt[AMT_W-1:0];
      2'b01:   eff_amt = in_regb[AMT_W-1:0];
      2'b10:   eff_amt = in_mem[AMT_W-1:0];
      default: eff_amt = AMT_CONST_T;
    endcase
  end

  assign rem_ext = {1'b0, rem_q};
  assign k       = (rem_ext < STEP_K) ? rem_ext : STEP_K;

  // SRA fills from result_q's MSB, which never changes during the operation.
  always_comb begin
    shifted = result_q;
    case (op_q)
      2'b00:   shifted = result_q << k;
      2'b01:   shifted = result_q >> k;
      2'b10:   shifted = $signed(result_q) >>> k;
      default: shifted = (result_q >> k) | (result_q << (WIDTH_K - k));
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          result_d = data_in;
          op_d     = op;
          rem_d    = eff_amt;
          state_d  = (eff_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        result_d = shifted;
        rem_d    = rem_q - k[AMT_W-1:0];
        if (rem_ext == k) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_engine.sv
// tb/tb_shift_engine.sv - random and directed checks of shift_engine at STEP=1 and STEP=4
module tb_shift_engine;

  localparam int DATA_W    = 32;
  localparam int AMT_CONST = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op, amt_sel;
  logic [15:0] in_shamt;
  logic [31:0] in_regb, in_mem, data_in;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_engine #(.DATA_W(DATA_W), .STEP(1), .AMT_CONST(AMT_CONST)) u_s1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt_sel(amt_sel),
    .in_shamt(in_shamt), .in_regb(in_regb), .in_mem(in_mem), .data_in(data_in),
    .busy(busy1), .done(done1), .result(result1)
  );

  shift_engine #(.DATA_W(DATA_W), .STEP(4), .AMT_CONST(AMT_CONST)) u_s4 (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt_sel(amt_sel),
    .in_shamt(in_shamt), .in_regb(in_regb), .in_mem(in_mem), .data_in(data_in),
    .busy(busy4), .done(done4), .result(result4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sel_amt(input logic [1:0] sel, input logic [15:0] sh,
                                 input logic [31:0] rb, input logic [31:0] mem);
    case (sel)
      2'b00:   return int'(sh) % DATA_W;
      2'b01:   return int'(rb % 32'd32);
      2'b10:   return int'(mem % 32'd32);
      default: return AMT_CONST % DATA_W;
    endcase
  endfunction

  function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int amt);
    logic signed [31:0] sd;
    logic [63:0]        dd;
    sd = d;
    dd = {d, d};
    case (o)
      2'b00:   return d << amt;
      2'b01:   return d >> amt;
      2'b10:   return sd >>> amt;
      default: begin
        dd = dd >> amt;
        return dd[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input int amt, input int step);
    return (amt == 0) ? 1 : (amt + step - 1) / step + 1;
  endfunction

  task automatic scramble();
    op       = 2'($urandom);
    amt_sel  = 2'($urandom);
    in_shamt = 16'($urandom);
    in_regb  = $urandom;
    in_mem   = $urandom;
    data_in  = $urandom;
  endtask

  // Called at a negedge; returns at a negedge with both engines idle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [1:0] sel,
                        input logic [15:0] sh, input logic [31:0] rb, input logic [31:0] mem,
                        input logic [31:0] d, input bit noise);
    int amt, cyc, lat1, lat4, bz1, bz4, dn1, dn4;
    logic [31:0] exp, r1, r4;
    amt = sel_amt(sel, sh, rb, mem);
    exp = ref_shift(o, d, amt);
    op = o; amt_sel = sel; in_shamt = sh; in_regb = rb; in_mem = mem; data_in = d;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (noise) scramble();
    cyc = 1; lat1 = 0; lat4 = 0; bz1 = 0; bz4 = 0; dn1 = 0; dn4 = 0; r1 = '0; r4 = '0;
    while ((lat1 == 0 || lat4 == 0) && cyc < 200) begin
      if (done1) begin dn1++; if (lat1 == 0) begin lat1 = cyc; r1 = result1; end end
      if (done4) begin dn4++; if (lat4 == 0) begin lat4 = cyc; r4 = result4; end end
      if (busy1) bz1++;
      if (busy4) bz4++;
      if (noise && (busy1 || done1) && (busy4 || done4)) begin
        start = 1'($urandom);
        scramble();
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (done1) dn1++;
      if (done4) dn4++;
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, " lat s1"},   lat1, ref_lat(amt, 1));
    check({tag, " lat s4"},   lat4, ref_lat(amt, 4));
    check({tag, " res s1"},   r1, exp);
    check({tag, " res s4"},   r4, exp);
    check({tag, " busy s1"},  bz1, ref_lat(amt, 1) - 1);
    check({tag, " busy s4"},  bz4, ref_lat(amt, 4) - 1);
    check({tag, " dones s1"}, dn1, 1);
    check({tag, " dones s4"}, dn4, 1);
    check({tag, " hold s1"},  result1, exp);
    check({tag, " hold s4"},  result4, exp);
  endtask

  initial begin
    int dn;
    reset = 1'b1; start = 1'b0;
    op = '0; amt_sel = '0; in_shamt = '0; in_regb = '0; in_mem = '0; data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", {busy1, busy4}, 2'b00);
    check("rst done", {done1, done4}, 2'b00);
    check("rst result", {result1, result4}, 64'h0);
    reset = 1'b0;

    run_op("sll31", 2'b00, 2'b00, 16'h001F, 32'h0, 32'h0, 32'h0000_0001, 1'b0);
    check("sll31 value", result1, 32'h8000_0000);
    run_op("sra4", 2'b10, 2'b01, 16'h0, 32'hFFFF_FFE4, 32'h0, 32'h8000_0000, 1'b0);
    check("sra4 value", result1, 32'hF800_0000);
    run_op("ror16", 2'b11, 2'b11, 16'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b1);
    check("ror16 value", result1, 32'h5678_1234);
    run_op("amt0", 2'b00, 2'b10, 16'h0, 32'h0, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0);
    check("amt0 value", result1, 32'hDEAD_BEEF);
    run_op("srl6", 2'b01, 2'b00, 16'h0006, 32'h0, 32'h0, 32'hF000_0000, 1'b1);
    check("srl6 value", result4, 32'h03C0_0000);

    // Reset in the middle of a long shift aborts it without a done pulse.
    op = 2'b00; amt_sel = 2'b00; in_shamt = 16'd20; data_in = 32'h0000_0001;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid busy s1", busy1, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", {busy1, busy4}, 2'b00);
    check("abort done", {done1, done4}, 2'b00);
    check("abort result", {result1, result4}, 64'h0);
    dn = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done1 || done4) dn++;
    end
    check("abort no done", dn, 0);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1; data_in = 32'hA5A5_A5A5; amt_sel = 2'b11;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst+start busy", {busy1, busy4, done1, done4}, 4'b0000);
    check("rst+start result", {result1, result4}, 64'h0);

    run_op("fresh", 2'b11, 2'b00, 16'h0005, 32'h0, 32'h0, 32'h0000_00FF, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_op($sformatf("rnd%0d", n), 2'($urandom), 2'($urandom), 16'($urandom),
             $urandom, $urandom, $urandom, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
